// File: rtl/axi_lite_reg_test_master.sv
// axi_lite_reg_test_master
//   Self-test AXI4-Lite master. On start it writes NUM_REGS registers
//   (address BASE_ADDR + i*bytes_per_word, data START_VALUE + i), then reads
//   them back in ascending order and compares each beat against the pattern.
//   Only one transaction is outstanding at a time.
// Ports
//   ACLK/ARESETN     clock, asynchronous active-low reset
//   start            begin a sequence (sampled only in IDLE or DONE)
//   busy/done/pass   status; done/pass hold until the next start
//   err_cnt          saturating count of bad responses and data mismatches
//   M_AXI_*          AXI4-Lite master channels (AW, W, B, AR, R)
module axi_lite_reg_test_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] START_VALUE = 1,
  parameter int TIMEOUT            = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [7:0]                      err_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int BPW = DW / 8;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      idx_q, idx_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [7:0]      err_q, err_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            aw_ok, w_ok, last;

  function automatic logic [AW-1:0] addr_of(input logic [8:0] i);
    return BASE_ADDR + AW'(i) * AW'(BPW);
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [8:0] i);
    return START_VALUE + DW'(i);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign last = (idx_q == 9'(NUM_REGS - 1));
  // A channel counts as finished once its VALID has been retired, either
  // on an earlier cycle or by the handshake happening right now.
  assign aw_ok = !awvalid_q || M_AXI_AWREADY;
  assign w_ok  = !wvalid_q  || M_AXI_WREADY;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_WR_ADDR;
          idx_d     = '0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = addr_of(9'd0);
          wdata_d   = data_of(9'd0);
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
        end
      end
      S_WR_ADDR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) err_d = sat_inc(err_q);
          if (last) begin
            idx_d     = '0;
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = addr_of(9'd0);
          end else begin
            idx_d     = idx_q + 9'd1;
            state_d   = S_WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = addr_of(idx_q + 9'd1);
            wdata_d   = data_of(idx_q + 9'd1);
          end
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          // Bad response and bad data on the same beat is one error.
          if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != data_of(idx_q))
            err_d = sat_inc(err_q);
          if (last) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 8'd0);
          end else begin
            idx_d     = idx_q + 9'd1;
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = addr_of(idx_q + 9'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stalled handshake: abandon the sequence and flag it as a hard failure.
    if (busy_q && state_d == state_q && wait_q >= TW'(TIMEOUT - 1)) begin
      state_d   = S_DONE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      err_d     = 8'hFF;
    end

    if (state_d != state_q || !busy_q) wait_d = '0;
    else                               wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wait_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_test_master.sv
// Directed bench for axi_lite_reg_test_master with a small memory slave.
// The slave has knobs for AWREADY delay/blocking, an SLVERR write response
// on address 0x0 and a corrupted read (0xDEAD) of address 0x8.
module tb_axi_lite_reg_test_master;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [7:0]  err_cnt;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  // slave knobs
  int   aw_delay = 0;
  logic aw_block = 1'b0;
  logic bresp_err_en = 1'b0;
  logic corrupt_en = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_reg_test_master #(.TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- slave + logs ----------------
  logic [31:0] mem [64];
  logic [31:0] wa [16];
  logic [31:0] wd [16];
  logic [31:0] ra [16];
  int          aw_cnt, wr_cnt, rd_cnt, awv_cyc, wv_cyc, proto;
  logic        aw_got, w_got, rd_early, aw_hold;
  logic [31:0] aw_a, w_d, aw_hold_a;
  logic        aw_hs, w_hs;
  logic [31:0] cur_a, cur_d;

  assign awready = !aw_block && (aw_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign cur_a   = aw_hs ? awaddr : aw_a;
  assign cur_d   = w_hs ? wdata : w_d;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      aw_cnt <= 0; wr_cnt <= 0; rd_cnt <= 0; awv_cyc <= 0; wv_cyc <= 0;
      proto <= 0; aw_got <= 0; w_got <= 0; rd_early <= 0; aw_hold <= 0;
      aw_a <= '0; w_d <= '0; aw_hold_a <= '0;
      bvalid <= 0; bresp <= '0; rvalid <= 0; rresp <= '0; rdata <= '0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else if (aw_hs)          aw_cnt <= 0;
      if (awvalid && wr_cnt == 0) awv_cyc <= awv_cyc + 1;
      if (wvalid && wr_cnt == 0)  wv_cyc  <= wv_cyc + 1;
      // AWADDR stability while stalled, and no BREADY with a write pending
      aw_hold   <= awvalid && !awready;
      aw_hold_a <= awaddr;
      if ((aw_hold && (!awvalid || awaddr != aw_hold_a)) ||
          (bready && (awvalid || wvalid)) || wstrb != 4'hF)
        proto <= proto + 1;
      if (aw_hs) begin aw_got <= 1; aw_a <= awaddr; end
      if (w_hs)  begin w_got <= 1;  w_d  <= wdata;  end
      if (bvalid && bready) bvalid <= 0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[cur_a[7:2]] <= cur_d;
        wa[wr_cnt[3:0]] <= cur_a;
        wd[wr_cnt[3:0]] <= cur_d;
        wr_cnt <= wr_cnt + 1;
        aw_got <= 0; w_got <= 0;
        bvalid <= 1;
        bresp  <= (bresp_err_en && cur_a == 32'h0) ? 2'b10 : 2'b00;
      end
      if (rvalid && rready) rvalid <= 0;
      if (arvalid && arready) begin
        rvalid <= 1;
        rresp  <= 2'b00;
        rdata  <= (corrupt_en && araddr == 32'h8) ? 32'hDEAD : mem[araddr[7:2]];
        ra[rd_cnt[3:0]] <= araddr;
        rd_cnt <= rd_cnt + 1;
        if (wr_cnt != 4) rd_early <= 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(posedge ACLK); #1;
  endtask

  // Pulse start, return number of rising edges from the start pulse until
  // done is seen. Optionally re-pulse start while busy.
  task automatic run_seq(input int extra_at, output int cyc);
    bit seen;
    seen = 0;
    cyc  = 0;
    @(posedge ACLK); #1 start = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(posedge ACLK);
      cyc++;
      #1 start = (cyc == extra_at);
      if (done) begin seen = 1; break; end
    end
    start = 1'b0;
    chk("run_done_seen", 64'(seen), 64'd1);
  endtask

  int c;

  initial begin
    // reset state
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_err", 64'(err_cnt), 0);
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 0);
    chk("rst_addr", 64'({awaddr, araddr, wdata}), 0);
    ARESETN = 1'b1;

    // ideal slave
    do_reset();
    run_seq(0, c);
    chk("ideal_latency", 64'(c), 17);
    chk("ideal_pass", 64'(pass), 1);
    chk("ideal_err", 64'(err_cnt), 0);
    chk("ideal_busy", 64'(busy), 0);
    chk("ideal_wr_cnt", 64'(wr_cnt), 4);
    chk("ideal_rd_cnt", 64'(rd_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ideal_wa%0d", i), 64'(wa[i]), 64'(4 * i));
      chk($sformatf("ideal_wd%0d", i), 64'(wd[i]), 64'(i + 1));
      chk($sformatf("ideal_ra%0d", i), 64'(ra[i]), 64'(4 * i));
    end
    chk("ideal_rd_after_wr", 64'(rd_early), 0);
    chk("ideal_proto", 64'(proto), 0);
    @(posedge ACLK); #1;
    chk("ideal_done_held", 64'(done), 1);

    // corrupted read data at 0x8
    corrupt_en = 1'b1;
    do_reset();
    run_seq(0, c);
    chk("corrupt_err", 64'(err_cnt), 1);
    chk("corrupt_pass", 64'(pass), 0);
    chk("corrupt_rd_cnt", 64'(rd_cnt), 4);
    corrupt_en = 1'b0;

    // SLVERR on write to 0x0
    bresp_err_en = 1'b1;
    do_reset();
    run_seq(0, c);
    chk("bresp_err", 64'(err_cnt), 1);
    chk("bresp_pass", 64'(pass), 0);
    chk("bresp_latency", 64'(c), 17);
    bresp_err_en = 1'b0;

    // restart from DONE clears status and reruns cleanly
    run_seq(0, c);
    chk("restart_err", 64'(err_cnt), 0);
    chk("restart_pass", 64'(pass), 1);
    chk("restart_latency", 64'(c), 17);

    // AWREADY held low -> timeout
    aw_block = 1'b1;
    do_reset();
    run_seq(0, c);
    chk("tmo_err", 64'(err_cnt), 8'hFF);
    chk("tmo_pass", 64'(pass), 0);
    chk("tmo_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 0);
    chk("tmo_window", 64'(c >= 14 && c <= 20), 1);
    chk("tmo_wv_cyc", 64'(wv_cyc), 1);
    aw_block = 1'b0;

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_delay = 3;
    do_reset();
    run_seq(0, c);
    chk("dly_awv_cyc", 64'(awv_cyc), 4);
    chk("dly_wv_cyc", 64'(wv_cyc), 1);
    chk("dly_proto", 64'(proto), 0);
    chk("dly_latency", 64'(c), 29);
    chk("dly_pass", 64'(pass), 1);
    aw_delay = 0;

    // reset while ARVALID is high
    do_reset();
    @(posedge ACLK); #1 start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
    c = 0;
    for (int k = 0; k < 100; k++) begin
      if (arvalid) break;
      @(posedge ACLK); #1;
      c++;
    end
    chk("mid_arvalid_seen", 64'(arvalid), 1);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({arvalid, awvalid, wvalid, bready, rready, busy, done, pass}), 0);
    chk("mid_rst_addr", 64'({araddr, awaddr}), 0);
    chk("mid_rst_err", 64'(err_cnt), 0);
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    repeat (5) @(posedge ACLK);
    #1;
    chk("mid_no_resume", 64'({busy, arvalid, awvalid}), 0);
    // start mid-run must be ignored
    run_seq(6, c);
    chk("busy_start_latency", 64'(c), 17);
    chk("busy_start_pass", 64'(pass), 1);
    chk("busy_start_wr_cnt", 64'(wr_cnt), 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
